input_fifo: RTL

INPUT_FIFO -- requirements
Module: input_fifo

---
 rtl/input_fifo.sv | 78 +++++++
 1 files changed

// File: rtl/input_fifo.sv
// input_fifo: FWFT flit FIFO with credit return, sticky overflow and packet-framing check (ports: clk, rst, valid_in, flit_in, rd_en -> flit_out, flit_id, dst_addr, empty, full, credit_out, proto_err, overflow)
module input_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] flit_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] flit_out,
  output logic [2:0]            flit_id,
  output logic [3:0]            dst_addr,
  output logic                  empty,
  output logic                  full,
  output logic                  credit_out,
  output logic                  proto_err,
  output logic                  overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] HEADER = 3'b001;
  localparam logic [2:0] PAYLOAD = 3'b000;
  localparam logic [2:0] TAIL = 3'b100;
  typedef enum logic {IDLE, IN_PKT} state_t;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t state_q, state_d;
  logic credit_q, credit_d, proto_err_q, proto_err_d, overflow_q, overflow_d;
  logic wr, rd, bad;
  logic [2:0] in_id;
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
  assign flit_out = mem[rd_ptr_q];
  assign flit_id = flit_out[31:29];
  assign dst_addr = flit_out[7:4];
  assign credit_out = credit_q;
  assign proto_err = proto_err_q;
  assign overflow = overflow_q;
  always_comb begin
    rd = rd_en && !empty;
    wr = valid_in && (!full || rd_en);
    in_id = flit_in[31:29];
    wr_ptr_d = wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d = count_q + CW'(wr) - CW'(rd);
    state_d = !wr ? state_q : in_id == HEADER ? IN_PKT : in_id == TAIL ? IDLE : state_q;
    bad = (in_id == HEADER && state_q == IN_PKT) ||
          ((in_id == PAYLOAD || in_id == TAIL) && state_q == IDLE) ||
          !(in_id inside {HEADER, PAYLOAD, TAIL});
    proto_err_d = proto_err_q || (wr && bad);
    overflow_d = overflow_q || (valid_in && full && !rd_en);
    credit_d = rd;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      state_q <= IDLE;
      credit_q <= 1'b0;
      proto_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      state_q <= state_d;
      credit_q <= credit_d;
      proto_err_q <= proto_err_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr && !rst) mem[wr_ptr_q] <= flit_in;
  end
endmodule
